// File: rtl/rom8_stream.sv
// rom8_stream: walks a ROM address range (with wrap) and streams the
// returned bytes out through a small credit-controlled FIFO.
//
// Ports:
//   CLKIN, RESET        clock, synchronous active-high reset
//   START, BASE, LEN    command: first address and byte count (0 ignored,
//                       >256 clamped to 256), sampled only while idle
//   BUSY, DONE          job active / pulse when last byte leaves
//   ADDR, DATA          ROM address (registered) and 1-cycle-late read data
//   O_DATA, O_VALID,
//   O_READY             valid/ready byte stream
module rom8_stream #(
  parameter int DEPTH = 4
) (
  input  logic       CLKIN,
  input  logic       RESET,
  input  logic       START,
  input  logic [7:0] BASE,
  input  logic [8:0] LEN,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] ADDR,
  input  logic [7:0] DATA,
  output logic [7:0] O_DATA,
  output logic       O_VALID,
  input  logic       O_READY
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state, state_n;

  logic [7:0]    nxt;
  logic [8:0]    rem;
  logic [8:0]    len_c;
  logic          v1;
  logic          v2;
  logic          start_ok;
  logic          issue;
  logic          push;
  logic          pop;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd;
  logic [PW-1:0] wr;
  logic [CW-1:0] cnt;
  int            occ;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // v1: an address sits on ADDR this cycle (ROM samples it at the edge).
  // v2: DATA carries a requested byte this cycle and is pushed at the edge.
  assign push    = v2;
  assign O_VALID = (cnt != '0);
  assign pop     = O_VALID & O_READY;
  assign O_DATA  = O_VALID ? mem[rd] : 8'h00;
  assign BUSY    = (state != IDLE);
  assign len_c   = (LEN > 9'd256) ? 9'd256 : LEN;

  // Occupancy once this edge retires: FIFO after pop plus both pipeline
  // slots. A new issue is allowed only if it still fits in DEPTH.
  always_comb begin
    occ = int'(cnt) + int'(v1) + int'(v2) - int'(pop);
  end

  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    start_ok = 1'b0;
    issue    = 1'b0;
    DONE     = 1'b0;
    unique case (state)
      IDLE: begin
        if (START && (LEN != 9'd0)) begin
          start_ok = 1'b1;
          state_n  = (len_c == 9'd1) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (occ < DEPTH) begin
          issue = 1'b1;
          if (rem == 9'd1) begin
            state_n = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && (cnt == CW'(1)) && !v1 && !v2) begin
          DONE    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The accepting edge already issues BASE, so the first byte is
  // on ADDR in the cycle right after START.
  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      ADDR <= 8'h00;
      nxt  <= 8'h00;
      rem  <= 9'd0;
      v1   <= 1'b0;
      v2   <= 1'b0;
      rd   <= '0;
      wr   <= '0;
      cnt  <= '0;
    end else begin
      v1 <= start_ok | issue;
      v2 <= v1;
      if (start_ok) begin
        ADDR <= BASE;
        nxt  <= BASE + 8'd1;
        rem  <= len_c - 9'd1;
      end else if (issue) begin
        ADDR <= nxt;
        nxt  <= nxt + 8'd1;
        rem  <= rem - 9'd1;
      end
      if (push) begin
        wr <= inc(wr);
      end
      if (pop) begin
        rd <= inc(rd);
      end
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge CLKIN) begin
    if (push) begin
      mem[wr] <= DATA;
    end
  end

endmodule

// File: tb/tb_rom8_stream.sv
// tb_rom8_stream: identity ROM, byte-queue reference model, vector table,
// directed corner sequences and randomized jobs with random back-pressure.
module tb_rom8_stream;

  localparam int DEPTH = 4;

  logic       CLKIN = 1'b0;
  logic       RESET;
  logic       START;
  logic [7:0] BASE;
  logic [8:0] LEN;
  logic       BUSY;
  logic       DONE;
  logic [7:0] ADDR;
  logic [7:0] DATA;
  logic [7:0] O_DATA;
  logic       O_VALID;
  logic       O_READY;

  always #5 CLKIN = ~CLKIN;

  // 256x8 ROM with identity contents and one cycle of read latency
  always @(posedge CLKIN) DATA <= ADDR;

  rom8_stream #(.DEPTH(DEPTH)) dut (
    .CLKIN(CLKIN),
    .RESET(RESET),
    .START(START),
    .BASE(BASE),
    .LEN(LEN),
    .BUSY(BUSY),
    .DONE(DONE),
    .ADDR(ADDR),
    .DATA(DATA),
    .O_DATA(O_DATA),
    .O_VALID(O_VALID),
    .O_READY(O_READY)
  );

  typedef struct {
    logic [7:0] base;
    logic [8:0] len;
    int         n;
    logic [7:0] first;
    logic [7:0] last;
  } vec_t;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         ndone = 0;
  logic [7:0] q[$];
  bit         mbusy = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data;
  bit         xfer;
  bit         xdone;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // One clock: drive at the falling edge, let logic settle, then compare
  // against the byte queue and advance the model.
  task automatic step(input bit st, input logic [7:0] b,
                      input logic [8:0] l, input bit rdy, input bit rst);
    int n;
    @(negedge CLKIN);
    START   = st;
    BASE    = b;
    LEN     = l;
    O_READY = rdy;
    RESET   = rst;
    #1;
    cyc++;
    chk("busy", BUSY, mbusy);
    if (prev_stall) begin
      chk("hold_valid", O_VALID, 1);
      chk("hold_data", O_DATA, prev_data);
    end
    if (O_VALID === 1'b1 && q.size() == 0) chk("spurious_valid", O_VALID, 0);
    xfer  = (O_VALID === 1'b1) && rdy;
    xdone = 1'b0;
    if (xfer && q.size() > 0) begin
      chk("data", O_DATA, q[0]);
      xdone = (q.size() == 1);
      void'(q.pop_front());
    end
    chk("done", DONE, xdone);
    if (DONE === 1'b1) ndone++;
    prev_stall = (O_VALID === 1'b1) && !rdy && !rst;
    prev_data  = O_DATA;
    if (rst) begin
      q.delete();
      mbusy      = 1'b0;
      prev_stall = 1'b0;
    end else if (xdone) begin
      mbusy = 1'b0;
    end else if (st && !mbusy && l != 9'd0) begin
      mbusy = 1'b1;
      n = (l > 9'd256) ? 256 : int'(l);
      for (int i = 0; i < n; i++) q.push_back(8'(b + 8'(i)));
    end
  endtask

  function automatic bit rdy_of(input int mode, input int n);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (n % 2) == 0;
    return $urandom_range(0, 3) != 0;
  endfunction

  task automatic run_idle(input int mode, input int budget);
    int n = 0;
    while (mbusy && n < budget) begin
      step(0, 8'h00, 9'd0, rdy_of(mode, n), 0);
      n++;
    end
    chk("timeout_busy", mbusy, 0);
  endtask

  vec_t vt[9];

  initial begin
    int c0, first, done_at, nb, got;
    logic [7:0] fb, lb;

    vt[0] = '{8'h10, 9'd4,   4,   8'h10, 8'h13};
    vt[1] = '{8'hFE, 9'd4,   4,   8'hFE, 8'h01};
    vt[2] = '{8'h00, 9'd1,   1,   8'h00, 8'h00};
    vt[3] = '{8'hFF, 9'd2,   2,   8'hFF, 8'h00};
    vt[4] = '{8'h30, 9'd0,   0,   8'h00, 8'h00};
    vt[5] = '{8'h00, 9'd256, 256, 8'h00, 8'hFF};
    vt[6] = '{8'h05, 9'd300, 256, 8'h05, 8'h04};
    vt[7] = '{8'hC0, 9'd511, 256, 8'hC0, 8'hBF};
    vt[8] = '{8'hFF, 9'd257, 256, 8'hFF, 8'hFE};

    RESET   = 1'b1;
    START   = 1'b0;
    BASE    = 8'h00;
    LEN     = 9'd0;
    O_READY = 1'b0;
    repeat (2) @(posedge CLKIN);
    step(0, 8'h00, 9'd0, 0, 1);
    step(0, 8'h00, 9'd0, 0, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_addr", ADDR, 0);
    chk("rst_valid", O_VALID, 0);
    chk("rst_odata", O_DATA, 0);

    // Vector table, consumer always ready: exact latency and count
    for (int v = 0; v < 9; v++) begin
      c0 = cyc + 1;
      first = -1;
      done_at = -1;
      nb = 0;
      fb = 8'h00;
      lb = 8'h00;
      step(1, vt[v].base, vt[v].len, 1, 0);
      for (int k = 0; k < 300 && mbusy; k++) begin
        step(0, 8'h00, 9'd0, 1, 0);
        if (xfer) begin
          if (first < 0) begin
            first = cyc;
            fb = O_DATA;
          end
          lb = O_DATA;
          nb++;
        end
        if (DONE === 1'b1) done_at = cyc;
      end
      for (int k = 0; k < 3; k++) begin
        step(0, 8'h00, 9'd0, 1, 0);
        if (xfer) nb++;
      end
      chk("vec_count", nb, vt[v].n);
      if (vt[v].n > 0) begin
        chk("vec_first_cyc", first, c0 + 3);
        chk("vec_done_cyc", done_at, c0 + 2 + vt[v].n);
        chk("vec_first", fb, vt[v].first);
        chk("vec_last", lb, vt[v].last);
      end
    end

    // Stall: only DEPTH addresses may be issued while the consumer waits
    step(1, 8'h00, 9'd8, 0, 0);
    repeat (9) step(0, 8'h00, 9'd0, 0, 0);
    chk("stall_addr", ADDR, DEPTH - 1);
    chk("stall_valid", O_VALID, 1);
    chk("stall_odata", O_DATA, 8'h00);
    run_idle(0, 50);
    chk("stall_left", q.size(), 0);

    // Alternating ready, full 256-byte walk, single DONE
    ndone = 0;
    step(1, 8'h00, 9'd256, 1, 0);
    run_idle(1, 1200);
    chk("toggle_done_cnt", ndone, 1);

    // START while busy must be ignored
    step(1, 8'h20, 9'd6, 1, 0);
    step(0, 8'h00, 9'd0, 1, 0);
    step(1, 8'h80, 9'd5, 1, 0);
    run_idle(0, 50);
    repeat (4) step(0, 8'h00, 9'd0, 1, 0);
    chk("ignored_addr", ADDR, 8'h25);

    // Reset in mid-stream with bytes buffered, START in the same cycle
    got = 0;
    step(1, 8'h40, 9'd20, 1, 0);
    for (int k = 0; k < 20 && got < 3; k++) begin
      step(0, 8'h00, 9'd0, 1, 0);
      if (xfer) got++;
    end
    chk("mid_got", got, 3);
    step(0, 8'h00, 9'd0, 0, 0);
    step(0, 8'h00, 9'd0, 0, 0);
    chk("mid_fifo_valid", O_VALID, 1);
    step(1, 8'h77, 9'd9, 0, 1);
    step(0, 8'h00, 9'd0, 0, 0);
    chk("mid_valid", O_VALID, 0);
    chk("mid_busy", BUSY, 0);
    chk("mid_done", DONE, 0);
    chk("mid_addr", ADDR, 0);
    step(1, 8'h90, 9'd5, 1, 0);
    run_idle(0, 30);
    chk("mid_left", q.size(), 0);

    // Random jobs, random back-pressure, stray STARTs, back-to-back starts
    for (int j = 0; j < 40; j++) begin
      int r;
      logic [8:0] l;
      r = $urandom_range(0, 9);
      if (r == 0) l = 9'd0;
      else if (r == 1) l = 9'($urandom_range(257, 511));
      else l = 9'($urandom_range(1, 20));
      repeat ($urandom_range(0, 2)) step(0, 8'h00, 9'd0, 1, 0);
      step(1, 8'($urandom), l, $urandom_range(0, 1) == 1, 0);
      for (int k = 0; k < 2000 && mbusy; k++) begin
        step($urandom_range(0, 7) == 0, 8'($urandom), 9'($urandom),
             rdy_of(2, k), 0);
      end
      chk("rand_timeout", mbusy, 0);
    end
    repeat (3) step(0, 8'h00, 9'd0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
